div16_seq: RTL



---
 rtl/div16_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div16_seq.sv
// Iterative unsigned restoring divider: one quotient bit per clock under a
// start/done handshake. A zero divisor short-circuits to a one-cycle result.
`timescale 1ns/1ps
module div16_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [WIDTH-1:0] r_d, w_d_nxt;
  // Partial remainder is always < D between steps, so WIDTH bits hold it;
  // the extra bit only exists transiently in the shifted value below.
  logic [WIDTH-1:0] r_r, w_r_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_quo, w_quo_nxt;
  logic [WIDTH-1:0] r_rem, w_rem_nxt;
  logic             r_dbz, w_dbz_nxt;
  logic             r_done, w_done_nxt;

  logic [WIDTH:0]   w_r_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_r_sub;
  logic [WIDTH-1:0] w_r_step;
  logic [WIDTH-1:0] w_q_step;

  // One restoring step: shift in the next dividend bit, trial-subtract D.
  always_comb begin
    w_r_shift = {r_r, r_q[WIDTH-1]};
    w_ge      = (w_r_shift >= {1'b0, r_d});
    // When w_ge holds the true difference is < D, so modulo-2^WIDTH is exact.
    w_r_sub   = w_r_shift[WIDTH-1:0] - r_d;
    w_r_step  = w_ge ? w_r_sub : w_r_shift[WIDTH-1:0];
    w_q_step  = {r_q[WIDTH-2:0], w_ge};
  end

  // Next-state and datapath control for the IDLE/RUN controller.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_d_nxt     = r_d;
    w_r_nxt     = r_r;
    w_cnt_nxt   = r_cnt;
    w_quo_nxt   = r_quo;
    w_rem_nxt   = r_rem;
    w_dbz_nxt   = r_dbz;
    w_done_nxt  = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) begin
          if (divisor != '0) begin
            w_q_nxt     = dividend;
            w_d_nxt     = divisor;
            w_r_nxt     = '0;
            w_cnt_nxt   = CntW'(WIDTH);
            w_state_nxt = StRun;
          end else begin
            w_quo_nxt  = '1;
            w_rem_nxt  = dividend;
            w_dbz_nxt  = 1'b1;
            w_done_nxt = 1'b1;
          end
        end
      end
      StRun: begin
        w_q_nxt   = w_q_step;
        w_r_nxt   = w_r_step;
        w_cnt_nxt = r_cnt - CntW'(1);
        if (r_cnt == CntW'(1)) begin
          w_quo_nxt   = w_q_step;
          w_rem_nxt   = w_r_step;
          w_dbz_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight division.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_q     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_d     <= w_d_nxt;
      r_r     <= w_r_nxt;
      r_cnt   <= w_cnt_nxt;
      r_quo   <= w_quo_nxt;
      r_rem   <= w_rem_nxt;
      r_dbz   <= w_dbz_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    busy        = (r_state == StRun);
    done        = r_done;
    quotient    = r_quo;
    remainder   = r_rem;
    div_by_zero = r_dbz;
  end

endmodule
